mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage access sequencer for the pipelined LC-3b. Sits directly downstream of the control ROM: it consumes the MEM-stage copy of the control word (mem_read, mem_write, is_ldi, is_sti, mem_byte_enable) and drives the data-cache port.
- Single accesses (LDR/STR/LDB/STB/TRAP) complete in one handshake. LDI/STI are sequenced as two back-to-back accesses.
- Stalls the pipeline until the access completes. Holds the result if the rest of the pipeline is frozen when the response arrives.

Parameters:
- ADDR_WIDTH, 16, address width of addr_in and dmem_address
- DATA_WIDTH, 16, data width of all data buses

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- valid_in  in  1  MEM stage holds a valid instruction
- mem_read_in  in  1  control word mem_read
- mem_write_in  in  1  control word mem_write
- is_ldi_in  in  1  control word is_ldi
- is_sti_in  in  1  control word is_sti
- byte_enable_in  in  2  control word mem_byte_enable
- addr_in  in  ADDR_WIDTH  effective address (ALU result)
- wdata_in  in  DATA_WIDTH  store data
- hold_in  in  1  pipeline frozen by another source (e.g. I-cache miss)
- dmem_resp  in  1  data-cache response, one-cycle pulse
- dmem_rdata  in  DATA_WIDTH  data-cache read data, valid with dmem_resp
- dmem_read  out  1  data-cache read request
- dmem_write  out  1  data-cache write request
- dmem_address  out  ADDR_WIDTH  data-cache address
- dmem_byte_enable  out  2  data-cache byte mask
- dmem_wdata  out  DATA_WIDTH  data-cache write data
- stall_out  out  1  hold all pipeline stages
- rdata_out  out  DATA_WIDTH  load result for the MEM/WB register

Behaviour:
- Request classes, evaluated only when valid_in=1:
  - IND: is_ldi_in or is_sti_in. Takes priority over the mem_read/mem_write flags; STI arrives with mem_read=1.
  - RD: mem_read_in only.
  - WR: mem_write_in only.
  - NONE: otherwise.
- State register: IDLE, INDIRECT, DONE. Registers ptr_reg and result_reg.
- Reset values: state=IDLE, ptr_reg=0, result_reg=0. While rst=1, dmem_read, dmem_write and stall_out are forced to 0.
- All dmem_* outputs and stall_out are combinational from state and inputs.
- IDLE:
  - NONE: no request; stall_out=0.
  - RD: dmem_read=1, dmem_address=addr_in, dmem_byte_enable=byte_enable_in.
  - WR: dmem_write=1, same address and mask, dmem_wdata=wdata_in.
  - IND: dmem_read=1, dmem_address=addr_in, dmem_byte_enable=2'b11 (pointer fetch).
  - stall_out = request active and not (dmem_resp and final access and hold_in=0).
- Final-access response in IDLE (RD/WR):
  - rdata_out=dmem_rdata that cycle; result_reg<=dmem_rdata.
  - hold_in=0: stall_out=0, stay IDLE.
  - hold_in=1: go to DONE.
- IND pointer response in IDLE: ptr_reg<=dmem_rdata; go to INDIRECT. stall_out remains 1.
- INDIRECT:
  - LDI: dmem_read=1. STI: dmem_write=1 with dmem_wdata=wdata_in.
  - dmem_address=ptr_reg, dmem_byte_enable=2'b11.
  - The LDI/STI kind is taken from is_ldi_in/is_sti_in, which stay stable because the pipeline is stalled.
  - On dmem_resp: same completion rule as IDLE (to IDLE if hold_in=0, else DONE). result_reg captured for LDI.
  - valid_in is ignored in INDIRECT: a started access is never abandoned.
- DONE:
  - No dmem request is issued; the completed access is never re-issued. rdata_out=result_reg.
  - stall_out=0, so this stage does not add stall.
  - Leave to IDLE on the first cycle with hold_in=0.
- rdata_out = dmem_rdata in a completion cycle, else result_reg.
- dmem_resp while no request is outstanding is ignored. No state change.
- Reset mid-access: return to IDLE next edge. Any in-flight response is dropped.
- Word accesses pass addresses unmodified. Alignment is the datapath's responsibility.

Test Plan:
- LDR: valid, RD, addr_in=0x0040, resp after 3 cycles with rdata 0x1234 -> dmem_read high 3 cycles; stall_out 1,1,0; rdata_out=0x1234 in the resp cycle; state stays IDLE.
- STB high byte: WR, byte_enable_in=2'b10, addr 0x0051, wdata 0xAB00, resp after 2 cycles -> dmem_write=1, dmem_byte_enable=2'b10, dmem_wdata=0xAB00; stall drops in the resp cycle.
- LDI: addr 0x0100, first resp returns 0x2000, second resp returns 0xBEEF -> dmem_address 0x0100 then 0x2000, both reads; stall held until the second resp; rdata_out=0xBEEF.
- STI (mem_read_in=1, is_sti_in=1): addr 0x0200, pointer 0x3000, wdata 0x5A5A -> read at 0x0200, then write of 0x5A5A at 0x3000 with mask 2'b11.
- LDR completes with hold_in=1 for 4 cycles -> state DONE, no second dmem_read, rdata_out=result_reg stable; back to IDLE when hold_in drops.
- Reset asserted in INDIRECT -> next cycle IDLE, dmem_read=0, stall_out=0; a late dmem_resp is ignored.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-stage access sequencer for the pipelined LC-3b. It takes the MEM-stage
// copy of the control word and drives the data-cache port.
//   - LDR/STR/LDB/STB/TRAP: one data-cache handshake.
//   - LDI/STI: a pointer read at addr_in, then the real access at the fetched
//     pointer (read for LDI, write for STI).
// The pipeline is stalled until the final access of an instruction completes.
// If another source has frozen the pipeline (hold_in) when the final response
// arrives, the result is parked in result_q and the access is not repeated.
//
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   valid_in          MEM stage holds a valid instruction
//   mem_read_in       control word mem_read
//   mem_write_in      control word mem_write
//   is_ldi_in         control word is_ldi
//   is_sti_in         control word is_sti (arrives with mem_read_in=1)
//   byte_enable_in    control word mem_byte_enable
//   addr_in           effective address from the ALU
//   wdata_in          store data
//   hold_in           pipeline frozen by another source
//   dmem_resp         data-cache response, one-cycle pulse
//   dmem_rdata        data-cache read data, valid with dmem_resp
//   dmem_read         data-cache read request
//   dmem_write        data-cache write request
//   dmem_address      data-cache address
//   dmem_byte_enable  data-cache byte mask
//   dmem_wdata        data-cache write data
//   stall_out         hold all pipeline stages
//   rdata_out         load result for the MEM/WB register
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  is_ldi_in,
  input  logic                  is_sti_in,
  input  logic [1:0]            byte_enable_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  hold_in,
  input  logic                  dmem_resp,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [1:0]            dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  stall_out,
  output logic [DATA_WIDTH-1:0] rdata_out
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INDIRECT = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  // Request class decode. Indirect wins over the plain read/write flags
  // because STI is encoded with mem_read set.
  logic req_ind;
  logic req_rd;
  logic req_wr;

  always_comb begin
    req_ind = valid_in & (is_ldi_in | is_sti_in);
    req_rd  = valid_in & ~req_ind & mem_read_in;
    req_wr  = valid_in & ~req_ind & ~mem_read_in & mem_write_in;
  end

  // Next-state and cache-port outputs.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    result_d         = result_q;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = addr_in;
    dmem_byte_enable = byte_enable_in;
    dmem_wdata       = wdata_in;
    stall_out        = 1'b0;
    rdata_out        = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_ind) begin
          // Pointer fetch is always a full word.
          dmem_read        = 1'b1;
          dmem_byte_enable = 2'b11;
          stall_out        = 1'b1;
          if (dmem_resp) begin
            ptr_d   = ADDR_WIDTH'(dmem_rdata);
            state_d = ST_INDIRECT;
          end
        end else if (req_rd || req_wr) begin
          dmem_read  = req_rd;
          dmem_write = req_wr;
          stall_out  = 1'b1;
          if (dmem_resp) begin
            rdata_out = dmem_rdata;
            result_d  = dmem_rdata;
            if (hold_in) begin
              state_d = ST_DONE;
            end else begin
              stall_out = 1'b0;
            end
          end
        end
      end

      ST_INDIRECT: begin
        // valid_in is deliberately not consulted: a started access finishes.
        dmem_address     = ptr_q;
        dmem_byte_enable = 2'b11;
        stall_out        = 1'b1;
        if (is_ldi_in) begin
          dmem_read = 1'b1;
        end else begin
          dmem_write = 1'b1;
        end
        if (dmem_resp) begin
          rdata_out = dmem_rdata;
          if (is_ldi_in) begin
            result_d = dmem_rdata;
          end
          if (hold_in) begin
            state_d = ST_DONE;
          end else begin
            stall_out = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_DONE: begin
        // Access already completed; only wait for the freeze to lift.
        if (!hold_in) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset suppresses requests and stall; any response in flight is dropped.
    if (rst) begin
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      stall_out  = 1'b0;
      rdata_out  = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_in, mem_write_in, is_ldi_in, is_sti_in;
  logic [1:0]  byte_enable_in;
  logic [15:0] addr_in, wdata_in;
  logic        hold_in, dmem_resp;
  logic [15:0] dmem_rdata;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_address;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic        stall_out;
  logic [15:0] rdata_out;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .is_ldi_in(is_ldi_in), .is_sti_in(is_sti_in),
    .byte_enable_in(byte_enable_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .hold_in(hold_in), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .stall_out(stall_out), .rdata_out(rdata_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let them settle.
  task automatic drv(input logic v, rd, wr, ldi, sti, input logic [1:0] be,
                     input logic [15:0] a, wd, input logic h, rsp,
                     input logic [15:0] rdt);
    @(negedge clk);
    valid_in = v; mem_read_in = rd; mem_write_in = wr; is_ldi_in = ldi;
    is_sti_in = sti; byte_enable_in = be; addr_in = a; wdata_in = wd;
    hold_in = h; dmem_resp = rsp; dmem_rdata = rdt;
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_step: number of data-cache accesses already completed for the current
  // instruction; m_parked: instruction finished but the pipeline is frozen.
  int unsigned m_step, n_step;
  bit          m_parked, n_parked;
  logic [15:0] m_ptr, n_ptr, m_result, n_result;
  logic        e_req, e_read, e_write, e_stall;
  logic [15:0] e_addr, e_wdata, e_rdata;
  logic [1:0]  e_be;

  task automatic model_eval();
    int unsigned total;
    bit ind;
    e_req = 0; e_read = 0; e_write = 0; e_stall = 0;
    e_addr = '0; e_be = '0; e_wdata = '0; e_rdata = m_result;
    n_step = m_step; n_parked = m_parked; n_ptr = m_ptr; n_result = m_result;
    if (rst) begin
      n_step = 0; n_parked = 0; n_ptr = '0; n_result = '0;
      return;
    end
    if (m_parked) begin
      if (!hold_in) n_parked = 0;
      return;
    end
    ind = is_ldi_in || is_sti_in;
    total = 1;
    if (m_step == 1) begin
      total = 2; e_req = 1; e_addr = m_ptr; e_be = 2'b11;
      if (is_ldi_in) e_read = 1;
      else begin e_write = 1; e_wdata = wdata_in; end
    end else if (valid_in && ind) begin
      total = 2; e_req = 1; e_read = 1; e_addr = addr_in; e_be = 2'b11;
    end else if (valid_in && mem_read_in) begin
      e_req = 1; e_read = 1; e_addr = addr_in; e_be = byte_enable_in;
    end else if (valid_in && mem_write_in) begin
      e_req = 1; e_write = 1; e_addr = addr_in; e_be = byte_enable_in;
      e_wdata = wdata_in;
    end
    if (!e_req) return;
    e_stall = 1;
    if (dmem_resp) begin
      if (m_step + 1 == total) begin
        e_rdata = dmem_rdata;
        if (m_step == 0 || e_read) n_result = dmem_rdata;
        n_step = 0;
        n_parked = hold_in;
        e_stall = hold_in;
      end else begin
        n_ptr = dmem_rdata;
        n_step = m_step + 1;
      end
    end
  endtask

  // ---------------- IDLE decode vectors ----------------
  typedef struct {
    logic v, rd, wr, ldi, sti;
    logic [1:0] be;
    logic [15:0] a, wd;
    logic h;
    logic e_rd, e_wr, e_st;
    logic [15:0] e_a;
    logic [1:0] e_be;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'b11,16'h0040,16'h0000,1'b0, 1'b0,1'b0,1'b0,16'h0000,2'b00};
    tbl[1] = '{1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,16'h0040,16'h0000,1'b0, 1'b1,1'b0,1'b1,16'h0040,2'b01};
    tbl[2] = '{1'b1,1'b0,1'b1,1'b0,1'b0,2'b10,16'h0051,16'hAB00,1'b0, 1'b0,1'b1,1'b1,16'h0051,2'b10};
    tbl[3] = '{1'b1,1'b1,1'b0,1'b1,1'b0,2'b01,16'h0100,16'h0000,1'b0, 1'b1,1'b0,1'b1,16'h0100,2'b11};
    tbl[4] = '{1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,16'h0200,16'h5A5A,1'b0, 1'b1,1'b0,1'b1,16'h0200,2'b11};
    tbl[5] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b11,16'h0300,16'h0000,1'b0, 1'b0,1'b0,1'b0,16'h0000,2'b00};
    tbl[6] = '{1'b1,1'b1,1'b0,1'b0,1'b0,2'b11,16'h0410,16'h0000,1'b1, 1'b1,1'b0,1'b1,16'h0410,2'b11};
    tbl[7] = '{1'b1,1'b0,1'b1,1'b0,1'b1,2'b01,16'h0500,16'h1111,1'b1, 1'b1,1'b0,1'b1,16'h0500,2'b11};

    rst = 1'b1;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; is_ldi_in = 1'b0;
    is_sti_in = 1'b0; byte_enable_in = 2'b00; addr_in = '0; wdata_in = '0;
    hold_in = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;

    // Reset forces requests and stall low even with a request present.
    drv(1,1,0,0,0,2'b11,16'h0040,16'h0,0,0,16'h0);
    chk("rst_read", 32'(dmem_read), 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    drv(0,0,0,0,0,2'b00,16'h0,16'h0,0,0,16'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_rdata", 32'(rdata_out), 32'h0);
    chk("post_rst_stall", 32'(stall_out), 32'h0);

    // Table: responses held low so the state stays IDLE throughout.
    for (int i = 0; i < 8; i++) begin
      drv(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].ldi, tbl[i].sti, tbl[i].be,
          tbl[i].a, tbl[i].wd, tbl[i].h, 1'b0, 16'h0);
      chk($sformatf("tbl%0d_read", i), 32'(dmem_read), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_write", i), 32'(dmem_write), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_out), 32'(tbl[i].e_st));
      chk($sformatf("tbl%0d_rdata", i), 32'(rdata_out), 32'h0);
      if (tbl[i].e_rd || tbl[i].e_wr) begin
        chk($sformatf("tbl%0d_addr", i), 32'(dmem_address), 32'(tbl[i].e_a));
        chk($sformatf("tbl%0d_be", i), 32'(dmem_byte_enable), 32'(tbl[i].e_be));
      end
      if (tbl[i].e_wr) chk($sformatf("tbl%0d_wdata", i), 32'(dmem_wdata), 32'(tbl[i].wd));
    end

    // LDR, response in the third cycle.
    drv(1,1,0,0,0,2'b11,16'h0040,16'h0,0,0,16'h0);
    chk("ldr_c1_read", 32'(dmem_read), 32'h1);
    chk("ldr_c1_stall", 32'(stall_out), 32'h1);
    chk("ldr_c1_addr", 32'(dmem_address), 32'h0040);
    drv(1,1,0,0,0,2'b11,16'h0040,16'h0,0,0,16'h0);
    chk("ldr_c2_read", 32'(dmem_read), 32'h1);
    chk("ldr_c2_stall", 32'(stall_out), 32'h1);
    drv(1,1,0,0,0,2'b11,16'h0040,16'h0,0,1,16'h1234);
    chk("ldr_c3_read", 32'(dmem_read), 32'h1);
    chk("ldr_c3_stall", 32'(stall_out), 32'h0);
    chk("ldr_c3_rdata", 32'(rdata_out), 32'h1234);
    drv(0,0,0,0,0,2'b00,16'h0,16'h0,0,0,16'h0);
    chk("ldr_after_read", 32'(dmem_read), 32'h0);
    chk("ldr_after_rdata", 32'(rdata_out), 32'h1234);

    // STB high byte.
    drv(1,0,1,0,0,2'b10,16'h0051,16'hAB00,0,0,16'h0);
    chk("stb_c1_write", 32'(dmem_write), 32'h1);
    chk("stb_c1_read", 32'(dmem_read), 32'h0);
    chk("stb_c1_be", 32'(dmem_byte_enable), 32'h2);
    chk("stb_c1_wdata", 32'(dmem_wdata), 32'hAB00);
    chk("stb_c1_addr", 32'(dmem_address), 32'h0051);
    chk("stb_c1_stall", 32'(stall_out), 32'h1);
    drv(1,0,1,0,0,2'b10,16'h0051,16'hAB00,0,1,16'h0000);
    chk("stb_c2_write", 32'(dmem_write), 32'h1);
    chk("stb_c2_stall", 32'(stall_out), 32'h0);

    // LDI: pointer 0x2000, data 0xBEEF.
    drv(1,1,0,1,0,2'b11,16'h0100,16'h0,0,0,16'h0);
    chk("ldi_c1_read", 32'(dmem_read), 32'h1);
    chk("ldi_c1_addr", 32'(dmem_address), 32'h0100);
    chk("ldi_c1_stall", 32'(stall_out), 32'h1);
    drv(1,1,0,1,0,2'b11,16'h0100,16'h0,0,1,16'h2000);
    chk("ldi_c2_read", 32'(dmem_read), 32'h1);
    chk("ldi_c2_stall", 32'(stall_out), 32'h1);
    drv(1,1,0,1,0,2'b11,16'h0100,16'h0,0,0,16'h0);
    chk("ldi_c3_read", 32'(dmem_read), 32'h1);
    chk("ldi_c3_addr", 32'(dmem_address), 32'h2000);
    chk("ldi_c3_be", 32'(dmem_byte_enable), 32'h3);
    chk("ldi_c3_stall", 32'(stall_out), 32'h1);
    drv(1,1,0,1,0,2'b11,16'h0100,16'h0,0,1,16'hBEEF);
    chk("ldi_c4_addr", 32'(dmem_address), 32'h2000);
    chk("ldi_c4_stall", 32'(stall_out), 32'h0);
    chk("ldi_c4_rdata", 32'(rdata_out), 32'hBEEF);
    drv(0,0,0,0,0,2'b00,16'h0,16'h0,0,0,16'h0);
    chk("ldi_after_read", 32'(dmem_read), 32'h0);
    chk("ldi_after_rdata", 32'(rdata_out), 32'hBEEF);

    // STI: pointer 0x3000, store 0x5A5A.
    drv(1,1,0,0,1,2'b01,16'h0200,16'h5A5A,0,1,16'h3000);
    chk("sti_c1_read", 32'(dmem_read), 32'h1);
    chk("sti_c1_addr", 32'(dmem_address), 32'h0200);
    chk("sti_c1_be", 32'(dmem_byte_enable), 32'h3);
    chk("sti_c1_stall", 32'(stall_out), 32'h1);
    drv(1,1,0,0,1,2'b01,16'h0200,16'h5A5A,0,0,16'h0);
    chk("sti_c2_write", 32'(dmem_write), 32'h1);
    chk("sti_c2_read", 32'(dmem_read), 32'h0);
    chk("sti_c2_addr", 32'(dmem_address), 32'h3000);
    chk("sti_c2_wdata", 32'(dmem_wdata), 32'h5A5A);
    chk("sti_c2_be", 32'(dmem_byte_enable), 32'h3);
    chk("sti_c2_stall", 32'(stall_out), 32'h1);
    drv(1,1,0,0,1,2'b01,16'h0200,16'h5A5A,0,1,16'h0000);
    chk("sti_c3_write", 32'(dmem_write), 32'h1);
    chk("sti_c3_stall", 32'(stall_out), 32'h0);
    drv(0,0,0,0,0,2'b00,16'h0,16'h0,0,0,16'h0);
    chk("sti_result_kept", 32'(rdata_out), 32'hBEEF);

    // LDR completing under hold_in for 4 cycles.
    drv(1,1,0,0,0,2'b11,16'h0060,16'h0,1,1,16'h7777);
    chk("hold_c1_read", 32'(dmem_read), 32'h1);
    chk("hold_c1_stall", 32'(stall_out), 32'h1);
    chk("hold_c1_rdata", 32'(rdata_out), 32'h7777);
    for (int k = 0; k < 3; k++) begin
      drv(1,1,0,0,0,2'b11,16'h0060,16'h0,1,0,16'h0);
      chk($sformatf("hold_done%0d_read", k), 32'(dmem_read), 32'h0);
      chk($sformatf("hold_done%0d_write", k), 32'(dmem_write), 32'h0);
      chk($sformatf("hold_done%0d_stall", k), 32'(stall_out), 32'h0);
      chk($sformatf("hold_done%0d_rdata", k), 32'(rdata_out), 32'h7777);
    end
    drv(1,1,0,0,0,2'b11,16'h0060,16'h0,0,0,16'h0);
    chk("hold_release_read", 32'(dmem_read), 32'h0);
    chk("hold_release_stall", 32'(stall_out), 32'h0);
    chk("hold_release_rdata", 32'(rdata_out), 32'h7777);
    drv(0,0,0,0,0,2'b00,16'h0,16'h0,0,0,16'h0);
    chk("hold_idle_read", 32'(dmem_read), 32'h0);
    drv(1,1,0,0,0,2'b11,16'h0070,16'h0,0,0,16'h0);
    chk("hold_next_read", 32'(dmem_read), 32'h1);
    chk("hold_next_addr", 32'(dmem_address), 32'h0070);
    drv(1,1,0,0,0,2'b11,16'h0070,16'h0,0,1,16'h0000);
    chk("hold_next_stall", 32'(stall_out), 32'h0);

    // Reset while in INDIRECT, then a late response.
    drv(1,1,0,1,0,2'b11,16'h0300,16'h0,0,1,16'h4000);
    chk("rsti_c1_addr", 32'(dmem_address), 32'h0300);
    drv(1,1,0,1,0,2'b11,16'h0300,16'h0,0,0,16'h0);
    chk("rsti_c2_addr", 32'(dmem_address), 32'h4000);
    @(negedge clk); rst = 1'b1; #1;
    chk("rsti_rst_read", 32'(dmem_read), 32'h0);
    chk("rsti_rst_stall", 32'(stall_out), 32'h0);
    @(negedge clk); rst = 1'b0; valid_in = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'hDEAD; #1;
    chk("rsti_late_read", 32'(dmem_read), 32'h0);
    chk("rsti_late_write", 32'(dmem_write), 32'h0);
    chk("rsti_late_stall", 32'(stall_out), 32'h0);
    chk("rsti_late_rdata", 32'(rdata_out), 32'h0);
    drv(1,1,0,0,0,2'b11,16'h0400,16'h0,0,0,16'h0);
    chk("rsti_next_addr", 32'(dmem_address), 32'h0400);
    chk("rsti_next_stall", 32'(stall_out), 32'h1);

    // Randomized traffic against the transaction model.
    begin
      bit new_ok = 1;
      m_step = 0; m_parked = 0; m_ptr = '0; m_result = '0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (new_ok) begin
          int unsigned cls = $urandom_range(0, 4);
          valid_in       = ($urandom_range(0, 9) != 0);
          mem_read_in    = (cls == 0 || cls == 2 || cls == 3);
          mem_write_in   = (cls == 1);
          is_ldi_in      = (cls == 2);
          is_sti_in      = (cls == 3);
          byte_enable_in = 2'($urandom_range(0, 3));
          addr_in        = 16'($urandom);
          wdata_in       = 16'($urandom);
        end
        hold_in    = ($urandom_range(0, 3) == 0);
        dmem_resp  = ($urandom_range(0, 2) == 0);
        dmem_rdata = 16'($urandom);
        rst        = (i == 0) || ($urandom_range(0, 99) == 0);
        #1;
        model_eval();
        chk("rnd_read", 32'(dmem_read), 32'(e_read));
        chk("rnd_write", 32'(dmem_write), 32'(e_write));
        chk("rnd_stall", 32'(stall_out), 32'(e_stall));
        chk("rnd_rdata", 32'(rdata_out), 32'(e_rdata));
        if (e_req) begin
          chk("rnd_addr", 32'(dmem_address), 32'(e_addr));
          chk("rnd_be", 32'(dmem_byte_enable), 32'(e_be));
        end
        if (e_write) chk("rnd_wdata", 32'(dmem_wdata), 32'(e_wdata));
        m_step = n_step; m_parked = n_parked; m_ptr = n_ptr; m_result = n_result;
        new_ok = rst || (!e_stall && !hold_in);
      end
      @(negedge clk); rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
